ppfifo_read_arbiter: RTL and testbench
======================================

PPFIFO_READ_ARBITER -- requirements
Module: ppfifo_read_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of each source's data and of the output stream data.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 24: width of each block-length count.
REQ-003 The block SHALL have input read_clock, width 1: the sole clock.
REQ-004 The block SHALL have input reset, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have input enable, width 1: when low, no new grants are issued.
REQ-006 The block SHALL have input src_ready[1:0], width 2: ppfifo read_ready, one bit per source.
REQ-007 The block SHALL have output src_activate[1:0], width 2: ppfifo read_activate, one bit per source.
REQ-008 The block SHALL have output src_strobe[1:0], width 2: ppfifo read_strobe, one bit per source.
REQ-009 The block SHALL have inputs src0_count and src1_count, width COUNT_WIDTH: ppfifo read_count of each source.
REQ-010 The block SHALL have inputs src0_data and src1_data, width DATA_WIDTH: ppfifo read_data of each source.
REQ-011 The block SHALL have output out_valid, width 1: output word available.
REQ-012 The block SHALL have input out_ready, width 1: downstream accepts the output word.
REQ-013 The block SHALL have output out_data, width DATA_WIDTH: output word.
REQ-014 The block SHALL have output out_last, width 1: current word is the last word of its block.
REQ-015 The block SHALL have output out_src, width 1: index of the granted source.
REQ-016 The block SHALL have output busy, width 1: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, STREAM and RELEASE.
REQ-018 IDLE SHALL transition to STREAM when enable=1 and any src_ready bit is set.
- On that transition the block registers the granted source in sel, sets src_activate[sel]=1, and loads remaining <= the granted source's count.
REQ-019 The grant SHALL be round-robin.
- If both src_ready bits are set, the source not granted last wins.
- If one bit is set, that source wins.
- last_grant resets to 1, so source 0 wins first.
REQ-020 In STREAM, out_valid SHALL equal (remaining != 0), and out_data SHALL combinationally mux src{sel}_data.
REQ-021 In STREAM, out_last SHALL equal (remaining == 1).
REQ-022 src_strobe[sel] SHALL equal out_valid & out_ready; the other strobe bit SHALL be 0 at all times.
REQ-023 Each handshake SHALL decrement remaining by 1; remaining SHALL never wrap below 0.
REQ-024 STREAM SHALL go to RELEASE in the cycle after remaining reaches 0, including immediately when the loaded count is 0 (no output words for a zero-count block).
REQ-025 RELEASE SHALL hold for one cycle, then go to IDLE.
- All src_activate bits are 0 in RELEASE.
- last_grant is updated to sel on entry to RELEASE.
- A new grant is therefore possible no earlier than the IDLE cycle that follows.
REQ-026 Deasserting enable during STREAM SHALL NOT abort the block; the block completes normally.
REQ-027 Changes on src_ready or on either count during STREAM SHALL be ignored.
REQ-028 out_valid, out_last and both src_strobe bits SHALL be 0 in IDLE and in RELEASE.
REQ-029 out_src SHALL equal sel in all states.
REQ-030 The latency from src_ready sampled high in IDLE to the first out_valid SHALL be exactly 1 cycle.

Reset
REQ-031 Asynchronous reset SHALL force the following, from any state including mid-block:
- state=IDLE, sel=0, last_grant=1, remaining=0
- src_activate=00, src_strobe=00
- out_valid=0, out_last=0, busy=0, out_src=0
REQ-032 After reset release, a partially drained block SHALL NOT be resumed; the ppfifo's own reset handling governs its contents.

Structure
REQ-033 The state encoding and the default COUNT_WIDTH=24 SHALL live in the shared package ppfifo_pkg.
REQ-034 The block SHALL be a single module with no sub-modules.
- The two-requester round-robin fits in fewer than 15 lines inline.

Verification
REQ-035 The bench SHALL drive src_ready=01 and src0_count=4 with out_ready=1 -> src_activate=01 one cycle later, 4 consecutive strobes, out_last on the 4th word, RELEASE, then IDLE.
REQ-036 The bench SHALL drive src_ready=11 from reset with both counts=2 -> source 0 is drained first, then source 1, with out_src 0,0 then 1,1.
REQ-037 The bench SHALL drive count=3 with out_ready toggling 1,0,1,0,1 -> exactly 3 strobes, data unchanged while out_ready=0, and remaining never wraps.
REQ-038 The bench SHALL drive count=0 -> STREAM with no out_valid, then RELEASE and IDLE, with activate high for exactly one cycle.
REQ-039 The bench SHALL assert reset after 2 of 8 words -> all outputs reach their reset values immediately, then busy=0.
REQ-040 The bench SHALL drop enable mid-block with count=5 -> all 5 words delivered, and no grant after RELEASE until enable returns to 1.

Source files
------------

// File: rtl/ppfifo_pkg.sv
// Shared ppfifo definitions: read-arbiter state encoding and the default count width.
package ppfifo_pkg;

    localparam int PPFIFO_COUNT_WIDTH = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_RELEASE = 2'd2
    } ppfifo_read_state_t;

endpackage

// File: rtl/ppfifo_read_arbiter.sv
// Round-robin arbiter draining whole blocks from two ppfifo read ports into one
// valid/ready output stream tagged with the granted source index.
module ppfifo_read_arbiter
    import ppfifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = PPFIFO_COUNT_WIDTH
) (
    input  logic                   read_clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             src_ready,
    output logic [1:0]             src_activate,
    output logic [1:0]             src_strobe,
    input  logic [COUNT_WIDTH-1:0] src0_count,
    input  logic [COUNT_WIDTH-1:0] src1_count,
    input  logic [DATA_WIDTH-1:0]  src0_data,
    input  logic [DATA_WIDTH-1:0]  src1_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   out_src,
    output logic                   busy,
    output ppfifo_read_state_t     debug_state
);

    ppfifo_read_state_t     state;
    logic                   sel;
    logic                   last_grant;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   grant_src;
    logic                   streaming;
    logic                   handshake;

    // Both requesting: the source not served last wins; otherwise the lone requester wins.
    always_comb begin
        grant_src = 1'b0;
        if (src_ready == 2'b11) begin
            grant_src = ~last_grant;
        end else begin
            grant_src = src_ready[1];
        end
    end

    // A word transfers in any cycle where out_valid and out_ready are both high;
    // out_valid never depends on out_ready, and a word is held until accepted.
    assign streaming   = (state == ST_STREAM);
    assign out_valid   = streaming && (remaining != '0);
    assign out_last    = streaming && (remaining == COUNT_WIDTH'(1));
    assign handshake   = out_valid && out_ready;
    assign src_strobe  = {sel & handshake, ~sel & handshake};
    assign out_data    = sel ? src1_data : src0_data;
    assign out_src     = sel;
    assign busy        = (state != ST_IDLE);
    assign debug_state = state;

    always_ff @(posedge read_clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sel          <= 1'b0;
            last_grant   <= 1'b1;
            remaining    <= '0;
            src_activate <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && (src_ready != 2'b00)) begin
                        state        <= ST_STREAM;
                        sel          <= grant_src;
                        remaining    <= grant_src ? src1_count : src0_count;
                        src_activate <= grant_src ? 2'b10 : 2'b01;
                    end
                end
                ST_STREAM: begin
                    // Count and ready inputs are ignored here; only the latched count drives the block.
                    if (remaining == '0) begin
                        state        <= ST_RELEASE;
                        src_activate <= 2'b00;
                        last_grant   <= sel;
                    end else if (handshake) begin
                        remaining <= remaining - COUNT_WIDTH'(1);
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    src_activate <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppfifo_read_arbiter.sv
// Directed bench for ppfifo_read_arbiter: a per-cycle vector table plus
// hand-written sequences for a scoreboarded drain and a mid-cycle reset.
module tb_ppfifo_read_arbiter;
    import ppfifo_pkg::*;

    localparam int DW = 32;
    localparam int CW = 24;

    logic          read_clock;
    logic          reset;
    logic          enable;
    logic [1:0]    src_ready;
    logic [1:0]    src_activate;
    logic [1:0]    src_strobe;
    logic [CW-1:0] src0_count;
    logic [CW-1:0] src1_count;
    logic [DW-1:0] src0_data;
    logic [DW-1:0] src1_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_src;
    logic          busy;
    ppfifo_read_state_t debug_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    ppfifo_read_arbiter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .read_clock   (read_clock),
        .reset        (reset),
        .enable       (enable),
        .src_ready    (src_ready),
        .src_activate (src_activate),
        .src_strobe   (src_strobe),
        .src0_count   (src0_count),
        .src1_count   (src1_count),
        .src0_data    (src0_data),
        .src1_data    (src1_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_src      (out_src),
        .busy         (busy),
        .debug_state  (debug_state)
    );

    // Clock and reset
    initial read_clock = 1'b0;
    always #5 read_clock = ~read_clock;

    // One row = inputs held for one cycle and the outputs expected in that cycle.
    typedef struct {
        int rst, en, rdy, ordy, c0, c1;
        int d0, d1;
        int act, stb, vld, lst, src, bsy, st;
        int dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rst, int en, int rdy, int ordy, int c0, int c1,
                                int d0, int d1, int act, int stb, int vld, int lst,
                                int src, int bsy, int st, int dat);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.ordy = ordy; v.c0 = c0; v.c1 = c1;
        v.d0 = d0; v.d1 = d1; v.act = act; v.stb = stb; v.vld = vld; v.lst = lst;
        v.src = src; v.bsy = bsy; v.st = st; v.dat = dat;
        return v;
    endfunction

    function automatic logic [9:0] pack_outputs();
        return {src_activate, src_strobe, out_valid, out_last, out_src, busy, 2'(debug_state)};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input vec_t v);
        reset      = 1'(v.rst);
        enable     = 1'(v.en);
        src_ready  = 2'(v.rdy);
        out_ready  = 1'(v.ordy);
        src0_count = CW'(v.c0);
        src1_count = CW'(v.c1);
        src0_data  = DW'(v.d0);
        src1_data  = DW'(v.d1);
    endtask

    task automatic fill_table();
        // Single source, count 4, out_ready held high
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0,      0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,1,1, 4,0, 'hA0,0,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,0,1, 4,0, 'hA1,0,   1,1,1,0,0,1,1, 'hA1));
        vecs.push_back(mk(0,1,0,1, 4,0, 'hA2,0,   1,1,1,0,0,1,1, 'hA2));
        vecs.push_back(mk(0,1,0,1, 4,0, 'hA3,0,   1,1,1,0,0,1,1, 'hA3));
        vecs.push_back(mk(0,1,0,1, 4,0, 'hA4,0,   1,1,1,1,0,1,1, 'hA4));
        vecs.push_back(mk(0,1,0,1, 4,0, 'hA5,0,   1,0,0,0,0,1,1, 0));
        vecs.push_back(mk(0,1,0,1, 0,0, 0,0,      0,0,0,0,0,1,2, 0));
        vecs.push_back(mk(0,1,0,1, 0,0, 0,0,      0,0,0,0,0,0,0, 0));
        // Both ready from reset, counts 2: source 0 then source 1
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0,      0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB0,'hC0, 0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB1,'hC0, 1,1,1,0,0,1,1, 'hB1));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB2,'hC0, 1,1,1,1,0,1,1, 'hB2));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB3,'hC0, 1,0,0,0,0,1,1, 0));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB3,'hC0, 0,0,0,0,0,1,2, 0));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB3,'hC0, 0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB3,'hC1, 2,2,1,0,1,1,1, 'hC1));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB3,'hC2, 2,2,1,1,1,1,1, 'hC2));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB3,'hC3, 2,0,0,0,1,1,1, 0));
        vecs.push_back(mk(0,1,3,1, 2,2, 'hB3,'hC3, 0,0,0,0,1,1,2, 0));
        vecs.push_back(mk(0,1,0,1, 2,2, 'hB3,'hC3, 0,0,0,0,1,0,0, 0));
        // Count 3 with out_ready toggling 1,0,1,0,1
        vecs.push_back(mk(0,1,1,1, 3,0, 'hD0,0,   0,0,0,0,1,0,0, 0));
        vecs.push_back(mk(0,1,0,1, 3,0, 'hD0,0,   1,1,1,0,0,1,1, 'hD0));
        vecs.push_back(mk(0,1,0,0, 3,0, 'hD1,0,   1,0,1,0,0,1,1, 'hD1));
        vecs.push_back(mk(0,1,0,1, 3,0, 'hD1,0,   1,1,1,0,0,1,1, 'hD1));
        vecs.push_back(mk(0,1,0,0, 3,0, 'hD2,0,   1,0,1,1,0,1,1, 'hD2));
        vecs.push_back(mk(0,1,0,1, 3,0, 'hD2,0,   1,1,1,1,0,1,1, 'hD2));
        vecs.push_back(mk(0,1,0,1, 3,0, 'hD3,0,   1,0,0,0,0,1,1, 0));
        vecs.push_back(mk(0,1,0,1, 3,0, 'hD3,0,   0,0,0,0,0,1,2, 0));
        vecs.push_back(mk(0,1,0,1, 3,0, 'hD3,0,   0,0,0,0,0,0,0, 0));
        // Zero-count block
        vecs.push_back(mk(0,1,1,1, 0,0, 0,0,      0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,0,1, 0,0, 0,0,      1,0,0,0,0,1,1, 0));
        vecs.push_back(mk(0,1,0,1, 0,0, 0,0,      0,0,0,0,0,1,2, 0));
        vecs.push_back(mk(0,1,0,1, 0,0, 0,0,      0,0,0,0,0,0,0, 0));
        // Reset after 2 of 8 words from source 1; no resume, no grant with enable low
        vecs.push_back(mk(0,1,2,1, 0,8, 0,'hE0,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,2,1, 0,8, 0,'hE0,   2,2,1,0,1,1,1, 'hE0));
        vecs.push_back(mk(0,1,2,1, 0,8, 0,'hE1,   2,2,1,0,1,1,1, 'hE1));
        vecs.push_back(mk(1,1,2,1, 0,8, 0,'hE2,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,1, 0,8, 0,'hE2,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,2,1, 0,8, 0,'hE2,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,2,1, 0,8, 0,'hE2,   0,0,0,0,0,0,0, 0));
        // Enable dropped mid-block, count 5; count/ready changes ignored while streaming
        vecs.push_back(mk(0,1,1,1, 5,0, 'hF0,0,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,2,1, 9,0, 'hF0,0,   1,1,1,0,0,1,1, 'hF0));
        vecs.push_back(mk(0,0,2,1, 9,0, 'hF1,0,   1,1,1,0,0,1,1, 'hF1));
        vecs.push_back(mk(0,0,2,1, 9,0, 'hF2,0,   1,1,1,0,0,1,1, 'hF2));
        vecs.push_back(mk(0,0,2,1, 9,0, 'hF3,0,   1,1,1,0,0,1,1, 'hF3));
        vecs.push_back(mk(0,0,2,1, 9,0, 'hF4,0,   1,1,1,1,0,1,1, 'hF4));
        vecs.push_back(mk(0,0,2,1, 9,0, 'hF5,0,   1,0,0,0,0,1,1, 0));
        vecs.push_back(mk(0,0,1,1, 9,0, 'hF5,0,   0,0,0,0,0,1,2, 0));
        vecs.push_back(mk(0,0,1,1, 9,0, 'hF5,0,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,1,1, 9,0, 'hF5,0,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,1,1, 1,0, 'hF6,0,   0,0,0,0,0,0,0, 0));
        vecs.push_back(mk(0,1,0,1, 1,0, 'hF7,0,   1,1,1,1,0,1,1, 'hF7));
        vecs.push_back(mk(0,1,0,1, 1,0, 'hF7,0,   1,0,0,0,0,1,1, 0));
        vecs.push_back(mk(0,1,0,1, 1,0, 'hF7,0,   0,0,0,0,0,1,2, 0));
        vecs.push_back(mk(0,1,0,1, 1,0, 'hF7,0,   0,0,0,0,0,0,0, 0));
    endtask

    // Drain a 3-word block from source 1 with random out_ready against a scoreboard.
    task automatic seq_scoreboard_drain();
        int  words;
        bit  done;
        words = 0;
        done  = 1'b0;
        @(negedge read_clock);
        enable = 1'b1; src_ready = 2'b10; src1_count = CW'(3); out_ready = 1'b0;
        src1_data = 32'h100;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i));
        @(negedge read_clock);
        src_ready = 2'b00;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            src1_data = 32'h100 + 32'(words);
            #1;
            if (!busy) begin
                done = 1'b1;
            end else if (out_valid && out_ready) begin
                check("drain_strobe", 32'(src_strobe), 32'h2);
                if (exp_q.size() > 0) check("drain_data", out_data, exp_q.pop_front());
                words++;
            end
            @(negedge read_clock);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: busy still 1 after 60 cycles, expected 0");
        end
        check("drain_words", 32'(words), 32'd3);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Reset asserted between clock edges must clear outputs without waiting for an edge.
    task automatic seq_async_reset();
        @(negedge read_clock);
        enable = 1'b1; src_ready = 2'b01; src0_count = CW'(8); out_ready = 1'b1;
        @(negedge read_clock);
        src_ready = 2'b00;
        @(negedge read_clock);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        @(posedge read_clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(pack_outputs()), 32'd0);
        @(negedge read_clock);
        reset = 1'b0;
        #1;
        check("post_reset_idle", 32'(pack_outputs()), 32'd0);
    endtask

    initial begin
        logic [9:0] exp_out;
        reset = 1'b1; enable = 1'b0; src_ready = 2'b00; out_ready = 1'b0;
        src0_count = '0; src1_count = '0; src0_data = '0; src1_data = '0;
        fill_table();
        repeat (2) @(posedge read_clock);
        foreach (vecs[i]) begin
            @(negedge read_clock);
            drive(vecs[i]);
            #1;
            exp_out = {2'(vecs[i].act), 2'(vecs[i].stb), 1'(vecs[i].vld), 1'(vecs[i].lst),
                       1'(vecs[i].src), 1'(vecs[i].bsy), 2'(vecs[i].st)};
            check($sformatf("row%0d_outputs", i), 32'(pack_outputs()), 32'(exp_out));
            if (vecs[i].vld != 0) check($sformatf("row%0d_data", i), out_data, 32'(vecs[i].dat));
        end
        seq_scoreboard_drain();
        seq_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
